telemetry_packetizer: RTL and testbench



---
 rtl/telemetry_packetizer_if.sv | 10 +
 rtl/telemetry_packetizer.sv | 180 ++++++++++++++++++
 tb/tb_telemetry_packetizer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/telemetry_packetizer_if.sv
// AXI-Stream master/slave bundle for the telemetry packetizer output.
interface telemetry_packetizer_if;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/telemetry_packetizer.sv
// Snapshots telemetry on each tick, frames it with a header and streams it over AXI-Stream.
// Optional CRC-32 trailer word when TELEM_CRC_EN is defined.
module telemetry_packetizer #(
    parameter int NUM_WORDS  = 20,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                      clk_i,
    input  logic                      reset,
    input  logic                      tick_i,
    input  logic [NUM_WORDS*32-1:0]   data_i,
    input  logic [31:0]               counter_i,
    telemetry_packetizer_if.master    m_axis,
    output logic [15:0]               drop_count_o,
    output logic                      busy_o
);

`ifdef TELEM_CRC_EN
    localparam int L = NUM_WORDS + 3;
`else
    localparam int L = NUM_WORDS + 2;
`endif
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     MAX_OCC  = (AW+1)'(FIFO_DEPTH - L);
    localparam logic [7:0]      LEN      = 8'(L);
    localparam logic [7:0]      LAST_IDX = 8'(L - 1);

    typedef enum logic {S_IDLE, S_WRITE} state_e;

    state_e                   state_q, state_d;
    logic [7:0]               widx_q, widx_d;
    logic [7:0]               seq_q, seq_d;
    logic [15:0]              drop_q, drop_d;
    logic [31:0]              cnt_snap_q, cnt_snap_d;
    logic [NUM_WORDS*32-1:0]  data_snap_q, data_snap_d;

    logic [32:0]              fifo_mem [FIFO_DEPTH];
    logic [AW:0]              wr_ptr_q, rd_ptr_q;
    logic [AW:0]              fifo_cnt;
    logic                     fifo_empty, space_ok, push, pop;

    logic [31:0]              tdata_q;
    logic                     tvalid_q, tlast_q;

    logic [31:0]              wr_word;
    logic                     wr_last;
    int                       pidx;

`ifdef TELEM_CRC_EN
    logic [31:0]              crc_q;

    function automatic logic [31:0] crc32_word(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction
`endif

    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_cnt == '0);
    assign space_ok   = (fifo_cnt <= MAX_OCC);
    assign push       = (state_q == S_WRITE);
    assign pop        = !fifo_empty && (!tvalid_q || m_axis.m_tready);
    assign wr_last    = (widx_q == LAST_IDX);

    always_comb begin
        pidx    = 0;
        wr_word = '0;
        if (widx_q == 8'd0) begin
            wr_word = {16'hA5A5, seq_q, LEN};
        end else if (widx_q == 8'd1) begin
            wr_word = cnt_snap_q;
`ifdef TELEM_CRC_EN
        end else if (wr_last) begin
            wr_word = crc_q;
`endif
        end else begin
            pidx    = int'(widx_q) - 2;
            wr_word = data_snap_q[pidx*32 +: 32];
        end
    end

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        seq_d       = seq_q;
        drop_d      = drop_q;
        cnt_snap_d  = cnt_snap_q;
        data_snap_d = data_snap_q;
        unique case (state_q)
            S_IDLE: begin
                if (tick_i) begin
                    if (space_ok) begin
                        cnt_snap_d  = counter_i;
                        data_snap_d = data_i;
                        widx_d      = 8'd0;
                        state_d     = S_WRITE;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            S_WRITE: begin
                widx_d = widx_q + 8'd1;
                if (wr_last) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = S_IDLE;
                end
                // a tick arriving mid-frame is lost; the snapshot stays untouched
                if (tick_i && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q     <= S_IDLE;
            widx_q      <= '0;
            seq_q       <= '0;
            drop_q      <= '0;
            cnt_snap_q  <= '0;
            data_snap_q <= '0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            seq_q       <= seq_d;
            drop_q      <= drop_d;
            cnt_snap_q  <= cnt_snap_d;
            data_snap_q <= data_snap_d;
        end
    end

`ifdef TELEM_CRC_EN
    always_ff @(posedge clk_i) begin
        if (reset) begin
            crc_q <= '0;
        end else if (push) begin
            crc_q <= crc32_word((widx_q == 8'd0) ? 32'hFFFFFFFF : crc_q, wr_word);
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {wr_last, wr_word};
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q           <= rd_ptr_q + 1'b1;
                tvalid_q           <= 1'b1;
                {tlast_q, tdata_q} <= fifo_mem[rd_ptr_q[AW-1:0]];
            end else if (m_axis.m_tready) begin
                tvalid_q <= 1'b0;
                tdata_q  <= '0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign m_axis.m_tdata  = tdata_q;
    assign m_axis.m_tvalid = tvalid_q;
    assign m_axis.m_tlast  = tlast_q;
    assign drop_count_o    = drop_q;
    assign busy_o          = (state_q == S_WRITE);

endmodule

// File: tb/tb_telemetry_packetizer.sv
// Directed bench for telemetry_packetizer (NUM_WORDS=4, FIFO_DEPTH=16); follows TELEM_CRC_EN if defined.
module tb_telemetry_packetizer;
    localparam int NW = 4;
    localparam int FD = 16;
`ifdef TELEM_CRC_EN
    localparam int L = NW + 3;
    localparam logic [31:0] HDR0 = 32'hA5A50007;
`else
    localparam int L = NW + 2;
    localparam logic [31:0] HDR0 = 32'hA5A50006;
`endif

    logic              clk_i = 1'b0;
    logic              reset;
    logic              tick_i;
    logic [NW*32-1:0]  data_i;
    logic [31:0]       counter_i;
    logic [15:0]       drop_count_o;
    logic              busy_o;
    logic              rand_ready = 1'b0;

    telemetry_packetizer_if axis ();

    telemetry_packetizer #(.NUM_WORDS(NW), .FIFO_DEPTH(FD)) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .tick_i       (tick_i),
        .data_i       (data_i),
        .counter_i    (counter_i),
        .m_axis       (axis),
        .drop_count_o (drop_count_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] cap_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

`ifdef TELEM_CRC_EN
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 31; b >= 0; b--) begin
            if (r[31] ^ d[b]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction
`endif

    task automatic push_frame(input logic [7:0] seq, input logic [31:0] cnt, input logic [NW*32-1:0] d);
        logic [31:0] w[$];
        logic        lst;
        w.push_back({16'hA5A5, seq, 8'(L)});
        w.push_back(cnt);
        for (int k = 0; k < NW; k++) w.push_back(d[k*32 +: 32]);
`ifdef TELEM_CRC_EN
        begin
            logic [31:0] crc;
            crc = 32'hFFFFFFFF;
            foreach (w[i]) crc = crc_step(crc, w[i]);
            w.push_back(crc);
        end
`endif
        foreach (w[i]) begin
            lst = (i == w.size() - 1);
            exp_q.push_back({lst, w[i]});
        end
    endtask

    task automatic tick_pulse(input logic [31:0] cnt, input logic [NW*32-1:0] d);
        counter_i = cnt;
        data_i    = d;
        tick_i    = 1'b1;
        step(1);
        tick_i    = 1'b0;
    endtask

    task automatic compare_stream(input string tag);
        int guard;
        guard = 0;
        while (cap_q.size() < exp_q.size() && guard < 3000) begin
            step(1);
            guard++;
        end
        if (guard >= 3000) check({tag, "_timeout"}, 64'(guard), 64'd0);
        step(L + 6);
        check({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check({tag, "_word"}, 64'(cap_q[i]), 64'(exp_q[i]));
        exp_q.delete();
        cap_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        exp_q.delete();
        cap_q.delete();
    endtask

    logic        had_stall = 1'b0;
    logic [32:0] stall_word;

    always @(negedge clk_i) begin
        if (reset) begin
            had_stall = 1'b0;
        end else begin
            if (had_stall)
                check("stall_hold", {31'd0, axis.m_tvalid, axis.m_tlast, axis.m_tdata},
                      {31'd0, 1'b1, stall_word});
            if (!axis.m_tvalid) check("tdata_idle_zero", 64'(axis.m_tdata), 64'd0);
            if (axis.m_tvalid && axis.m_tready) cap_q.push_back({axis.m_tlast, axis.m_tdata});
            had_stall  = axis.m_tvalid && !axis.m_tready;
            stall_word = {axis.m_tlast, axis.m_tdata};
        end
    end

    always @(posedge clk_i) begin
        if (rand_ready) begin
            #1;
            axis.m_tready = 1'($urandom_range(0, 1));
        end
    end

    localparam logic [NW*32-1:0] D0 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    initial begin
        reset         = 1'b1;
        tick_i        = 1'b0;
        data_i        = '0;
        counter_i     = '0;
        axis.m_tready = 1'b0;
        step(3);
        check("rst_tvalid", 64'(axis.m_tvalid), 64'd0);
        check("rst_tdata",  64'(axis.m_tdata),  64'd0);
        check("rst_tlast",  64'(axis.m_tlast),  64'd0);
        check("rst_drop",   64'(drop_count_o),  64'd0);
        check("rst_busy",   64'(busy_o),        64'd0);
        reset = 1'b0;
        step(1);

        // basic frame and latency
        axis.m_tready = 1'b1;
        tick_pulse(32'h00000007, D0);
        check("lat_busy", 64'(busy_o), 64'd1);
        check("lat_tvalid_n", 64'(axis.m_tvalid), 64'd0);
        step(1);
        check("lat_tvalid_n1", 64'(axis.m_tvalid), 64'd0);
        step(1);
        check("lat_tvalid_n2", 64'(axis.m_tvalid), 64'd1);
        check("lat_header", 64'(axis.m_tdata), 64'(HDR0));
        push_frame(8'd0, 32'h00000007, D0);
        compare_stream("basic");
        check("basic_idle", 64'(busy_o), 64'd0);

        // 300 frames: seq wraps 255 -> 0
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [NW*32-1:0] d;
            for (int k = 0; k < NW; k++) d[k*32 +: 32] = 32'(i * 16 + k);
            tick_pulse(32'(i), d);
            push_frame(8'(i), 32'(i), d);
            step(9);
        end
        compare_stream("seq_wrap");
        check("seq_wrap_drop", 64'(drop_count_o), 64'd0);

        // FIFO full drop, then drain and contiguous seq
        do_reset();
        axis.m_tready = 1'b0;
        tick_pulse(32'hA0, D0);
        push_frame(8'd0, 32'hA0, D0);
        step(12);
        tick_pulse(32'hA1, ~D0);
        push_frame(8'd1, 32'hA1, ~D0);
        step(12);
        tick_pulse(32'hA2, D0);
        step(2);
        check("full_drop", 64'(drop_count_o), 64'd1);
        axis.m_tready = 1'b1;
        compare_stream("full_drain");
        tick_pulse(32'hA3, D0);
        push_frame(8'd2, 32'hA3, D0);
        compare_stream("full_after");
        check("full_drop_hold", 64'(drop_count_o), 64'd1);

        // tick while writing
        do_reset();
        axis.m_tready = 1'b1;
        tick_pulse(32'hB0, D0);
        push_frame(8'd0, 32'hB0, D0);
        step(2);
        tick_pulse(32'hB1, ~D0);
        step(2);
        check("busy_drop", 64'(drop_count_o), 64'd1);
        compare_stream("busy_frame");

        // random backpressure
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [NW*32-1:0] d;
            for (int k = 0; k < NW; k++) d[k*32 +: 32] = 32'hC0DE0000 + 32'(i * 8 + k);
            tick_pulse(32'hC0 + 32'(i), d);
            push_frame(8'(i), 32'hC0 + 32'(i), d);
            step(40);
        end
        rand_ready = 1'b0;
        step(1);
        axis.m_tready = 1'b1;
        compare_stream("rand_ready");
        check("rand_drop", 64'(drop_count_o), 64'd0);

        // reset in the middle of a write
        do_reset();
        axis.m_tready = 1'b0;
        tick_pulse(32'hD0, D0);
        step(1);
        tick_pulse(32'hD1, D0);
        check("mid_drop_pre", 64'(drop_count_o), 64'd1);
        check("mid_busy_pre", 64'(busy_o), 64'd1);
        reset = 1'b1;
        step(1);
        check("mid_tvalid", 64'(axis.m_tvalid), 64'd0);
        check("mid_drop",   64'(drop_count_o),  64'd0);
        check("mid_busy",   64'(busy_o),        64'd0);
        reset = 1'b0;
        exp_q.delete();
        cap_q.delete();
        axis.m_tready = 1'b1;
        step(1);
        tick_pulse(32'hD2, D0);
        push_frame(8'd0, 32'hD2, D0);
        compare_stream("mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
